reg_file_3r1w: RTL and testbench

Architectural general-purpose register file for the out-of-order CPU core: three asynchronous read ports and one synchronous write port.
- Instantiated inside the register-status block, which pairs each register value with its producing-FU tag.
- Read ports serve instruction issue (up to three source operands).
- The write port is driven by the common-data-bus / commit path.

---
 rtl/reg_file_3r1w_pkg.sv | 13 +
 rtl/reg_file_3r1w_if.sv | 32 +++
 rtl/reg_file_3r1w_read_port.sv | 24 ++
 rtl/reg_file_3r1w.sv | 70 +++++++
 tb/tb_reg_file_3r1w.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_3r1w_pkg.sv
// Shared constants for the register file and the register-status block that wraps it.
// The size defaults parameterise the register file; the FU tag constants belong to the status table.
package reg_file_3r1w_pkg;

    localparam int DEF_WORD_SIZE     = 32;
    localparam int DEF_REG_INDEX     = 5;
    localparam int DEF_REG_FILE_SIZE = 32;

    // Producer tag width and the "value is ready" tag used by the enclosing status block
    localparam int                  FU_INDEX = 3;
    localparam logic [FU_INDEX-1:0] READY    = '0;

endpackage

// File: rtl/reg_file_3r1w_if.sv
// Operand-read and write-back bus of the register file.
// No handshake: read indices select values combinationally; the write strobe is sampled on the falling clock edge.
interface reg_file_3r1w_if
    import reg_file_3r1w_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int REG_INDEX = DEF_REG_INDEX
) ();

    logic [REG_INDEX-1:0] get_num1;
    logic [REG_INDEX-1:0] get_num2;
    logic [REG_INDEX-1:0] get_num3;
    logic [WORD_SIZE-1:0] value1;
    logic [WORD_SIZE-1:0] value2;
    logic [WORD_SIZE-1:0] value3;
    logic [REG_INDEX-1:0] write_reg_src;
    logic [WORD_SIZE-1:0] write_reg_data;
    logic                 write_reg_enable;

    modport master (
        output get_num1, get_num2, get_num3,
        output write_reg_src, write_reg_data, write_reg_enable,
        input  value1, value2, value3
    );

    modport slave (
        input  get_num1, get_num2, get_num3,
        input  write_reg_src, write_reg_data, write_reg_enable,
        output value1, value2, value3
    );

endinterface

// File: rtl/reg_file_3r1w_read_port.sv
// Combinational read mux over the register array.
// Indices that do not name an implemented register read as zero.
module reg_read_port
    import reg_file_3r1w_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int REG_INDEX     = DEF_REG_INDEX,
    parameter int REG_FILE_SIZE = DEF_REG_FILE_SIZE
) (
    input  logic [WORD_SIZE-1:0] i_regs [REG_FILE_SIZE],
    input  logic [REG_INDEX-1:0] i_index,
    output logic [WORD_SIZE-1:0] o_value
);

    always_comb begin
        o_value = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            if (i_index == REG_INDEX'(i)) begin
                o_value = i_regs[i];
            end
        end
    end

endmodule

// File: rtl/reg_file_3r1w.sv
// Architectural register file: three asynchronous read ports, one falling-edge write port.
// Register 0 is an ordinary register; reset clears every entry asynchronously.
module reg_file_3r1w
    import reg_file_3r1w_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int REG_INDEX     = DEF_REG_INDEX,
    parameter int REG_FILE_SIZE = DEF_REG_FILE_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    reg_file_3r1w_if.slave  bus
);

    logic [WORD_SIZE-1:0] r_regs [REG_FILE_SIZE];
    logic [WORD_SIZE-1:0] w_value1;
    logic [WORD_SIZE-1:0] w_value2;
    logic [WORD_SIZE-1:0] w_value3;

    // Falling edge keeps value and producer tag updating together in the status table.
    // Out-of-range destinations match no entry, so such writes drop out naturally.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.write_reg_enable) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                if (bus.write_reg_src == REG_INDEX'(i)) begin
                    r_regs[i] <= bus.write_reg_data;
                end
            end
        end
    end

    reg_read_port #(
        .WORD_SIZE     (WORD_SIZE),
        .REG_INDEX     (REG_INDEX),
        .REG_FILE_SIZE (REG_FILE_SIZE)
    ) u_read1 (
        .i_regs  (r_regs),
        .i_index (bus.get_num1),
        .o_value (w_value1)
    );

    reg_read_port #(
        .WORD_SIZE     (WORD_SIZE),
        .REG_INDEX     (REG_INDEX),
        .REG_FILE_SIZE (REG_FILE_SIZE)
    ) u_read2 (
        .i_regs  (r_regs),
        .i_index (bus.get_num2),
        .o_value (w_value2)
    );

    reg_read_port #(
        .WORD_SIZE     (WORD_SIZE),
        .REG_INDEX     (REG_INDEX),
        .REG_FILE_SIZE (REG_FILE_SIZE)
    ) u_read3 (
        .i_regs  (r_regs),
        .i_index (bus.get_num3),
        .o_value (w_value3)
    );

    assign bus.value1 = w_value1;
    assign bus.value2 = w_value2;
    assign bus.value3 = w_value3;

endmodule

// File: tb/tb_reg_file_3r1w.sv
// Self-checking bench for reg_file_3r1w: table-driven write/read vectors plus hand-written
// sequences for edge timing, reset clearing and the reset/write collision.
module tb_reg_file_3r1w;
    import reg_file_3r1w_pkg::*;

    localparam int W = DEF_WORD_SIZE;
    localparam int N = DEF_REG_FILE_SIZE;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_file_3r1w_if #(.WORD_SIZE(W), .REG_INDEX(DEF_REG_INDEX)) bus ();

    reg_file_3r1w #(
        .WORD_SIZE     (W),
        .REG_INDEX     (DEF_REG_INDEX),
        .REG_FILE_SIZE (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model [N];
    int n_vec;
    int n_err;

    typedef struct {
        logic       we;
        logic [4:0] src;
        logic [W-1:0] data;
        logic [4:0] g1, g2, g3;
        logic [W-1:0] e1, e2, e3;
    } vec_t;

    vec_t vecs [8];

    task automatic check_val(input string name, input logic [W-1:0] act);
        logic [W-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got %h but scoreboard queue empty", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", name, act, e);
            end
        end
    endtask

    // Drive read indices, push expectations, let the muxes settle, then compare.
    task automatic read_expect(input string name, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] c, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic [W-1:0] e3);
        bus.get_num1 = a;
        bus.get_num2 = b;
        bus.get_num3 = c;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
        #1;
        check_val({name, ".value1"}, bus.value1);
        check_val({name, ".value2"}, bus.value2);
        check_val({name, ".value3"}, bus.value3);
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c);
        read_expect(name, a, b, c, model[a], model[b], model[c]);
    endtask

    // ---------------- driver ----------------
    // Present the write just after a falling edge; it commits on the next one.
    task automatic do_write(input logic we, input logic [4:0] src, input logic [W-1:0] data);
        @(negedge clk);
        #1;
        bus.write_reg_enable = we;
        bus.write_reg_src    = src;
        bus.write_reg_data   = data;
        @(negedge clk);
        #1;
        if (we && !reset) model[src] = data;
        bus.write_reg_enable = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < N; i++) model[i] = '0;
        bus.get_num1 = '0;
        bus.get_num2 = '0;
        bus.get_num3 = '0;
        bus.write_reg_enable = 1'b0;
        bus.write_reg_src    = '0;
        bus.write_reg_data   = '0;

        vecs[0] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd1,  5'd1,  32'h1, 32'h1, 32'h1};
        vecs[1] = '{1'b1, 5'd2,  32'h0000_0002, 5'd1,  5'd2,  5'd0,  32'h1, 32'h2, 32'h0};
        vecs[2] = '{1'b1, 5'd3,  32'h0000_0003, 5'd1,  5'd2,  5'd3,  32'h1, 32'h2, 32'h3};
        vecs[3] = '{1'b0, 5'd3,  32'hFFFF_FFFF, 5'd3,  5'd3,  5'd3,  32'h3, 32'h3, 32'h3};
        vecs[4] = '{1'b1, 5'd0,  32'hA5A5_A5A5, 5'd0,  5'd7,  5'd3,  32'hA5A5_A5A5, 32'h1234_5678, 32'h3};
        vecs[5] = '{1'b1, 5'd31, 32'h5A5A_5A5A, 5'd31, 5'd0,  5'd1,  32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h1};
        vecs[6] = '{1'b1, 5'd1,  32'hCAFE_F00D, 5'd1,  5'd1,  5'd2,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'h2};
        vecs[7] = '{1'b0, 5'd31, 32'h0000_0000, 5'd31, 5'd30, 5'd7,  32'h5A5A_5A5A, 32'h0, 32'h1234_5678};

        // Reset state, while held and after release
        reset = 1'b1;
        #12;
        read_expect("reset_held", 5'd0, 5'd5, 5'd31, '0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        read_expect("reset_released", 5'd0, 5'd5, 5'd31, '0, '0, '0);

        // Single write: old value before the falling edge, no change on the rising edge
        @(negedge clk);
        #1;
        bus.write_reg_enable = 1'b1;
        bus.write_reg_src    = 5'd7;
        bus.write_reg_data   = 32'h1234_5678;
        read_expect("wr7_before_edge", 5'd7, 5'd7, 5'd0, '0, '0, '0);
        @(posedge clk);
        #1;
        read_expect("wr7_after_rise", 5'd7, 5'd7, 5'd0, '0, '0, '0);
        @(negedge clk);
        #1;
        bus.write_reg_enable = 1'b0;
        model[7] = 32'h1234_5678;
        read_expect("wr7_after_fall", 5'd7, 5'd0, 5'd7, 32'h1234_5678, '0, 32'h1234_5678);

        // Enable low for three falling edges
        bus.write_reg_src  = 5'd7;
        bus.write_reg_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        read_expect("enable_low", 5'd7, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);

        // Table-driven write/read vectors
        for (int v = 0; v < 8; v++) begin
            do_write(vecs[v].we, vecs[v].src, vecs[v].data);
            read_expect($sformatf("vec%0d", v), vecs[v].g1, vecs[v].g2, vecs[v].g3,
                        vecs[v].e1, vecs[v].e2, vecs[v].e3);
        end

        // Index changes with no clock edge in between
        read_check("comb_a", 5'd1, 5'd2, 5'd3);
        read_check("comb_b", 5'd3, 5'd2, 5'd1);
        read_check("comb_c", 5'd0, 5'd31, 5'd7);

        // Sweep every register to expose aliasing
        for (int i = 0; i < N; i++) do_write(1'b1, 5'(i), W'(i) * 32'h0101_0101);
        for (int i = 0; i < N; i++) begin
            read_expect($sformatf("sweep%0d", i), 5'(i), 5'(N - 1 - i), 5'((i + 1) % N),
                        W'(i) * 32'h0101_0101, W'(N - 1 - i) * 32'h0101_0101,
                        W'((i + 1) % N) * 32'h0101_0101);
        end

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            do_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, N - 1)), W'($urandom));
            read_check($sformatf("rand%0d", k), 5'($urandom_range(0, N - 1)),
                       5'($urandom_range(0, N - 1)), 5'($urandom_range(0, N - 1)));
        end

        // Mid-simulation reset clears immediately, without a clock edge
        do_write(1'b1, 5'd5, 32'hDEAD_BEEF);
        read_check("r5_written", 5'd5, 5'd0, 5'd31);
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < N; i++) model[i] = '0;
        read_expect("async_reset", 5'd0, 5'd5, 5'd31, '0, '0, '0);

        // Write colliding with reset at a falling edge is discarded
        bus.write_reg_enable = 1'b1;
        bus.write_reg_src    = 5'd4;
        bus.write_reg_data   = 32'h0000_0055;
        @(negedge clk);
        #1;
        read_expect("collide_held", 5'd4, 5'd4, 5'd0, '0, '0, '0);
        @(posedge clk);
        #1;
        bus.write_reg_enable = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        #1;
        read_expect("collide_released", 5'd4, 5'd5, 5'd31, '0, '0, '0);

        // Write path still works after reset
        do_write(1'b1, 5'd4, 32'h0000_0066);
        read_check("post_reset_wr", 5'd4, 5'd4, 5'd3);

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, 0 required", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
